// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and the
// line/frame total helper shared by the timing generator and its interface.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Total period (pixels per line or lines per frame) from its four regions.
  function automatic int calc_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video timing bundle driven by vga_timing_gen.
// Widths default to the 640x480 totals; override to match the generator.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int CW_H = $clog2(calc_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK)),
  parameter int CW_V = $clog2(calc_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK))
);

  logic            pix_en;
  logic            h_sync;
  logic            v_sync;
  logic            blank_n;
  logic [CW_H-1:0] pos_x;
  logic [CW_V-1:0] pos_y;
  logic            line_start;
  logic            frame_start;

  modport master (
    output pix_en, h_sync, v_sync, blank_n, pos_x, pos_y, line_start, frame_start
  );

  modport slave (
    input pix_en, h_sync, v_sync, blank_n, pos_x, pos_y, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift pipeline with a configurable reset
// value. DEPTH=0 is a plain wire so the caller can always instantiate it.
module vga_sync_delay #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift the group one stage per clk; reset fills every stage with idle levels.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA line/frame timing with pixel-clock divider.
// Optional macro VGA_SYNC_DELAY_EN delays h_sync, v_sync, blank_n,
// line_start and frame_start by SYNC_DLY clks relative to pix_en/pos.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int SYNC_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int CW_H    = $clog2(H_TOTAL);
  localparam int CW_V    = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW_H-1:0] H_LAST   = CW_H'(H_TOTAL - 1);
  localparam logic [CW_H-1:0] H_ACT    = CW_H'(H_ACTIVE);
  localparam logic [CW_H-1:0] HS_FIRST = CW_H'(H_ACTIVE + H_FRONT);
  localparam logic [CW_H-1:0] HS_LAST  = CW_H'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW_V-1:0] V_LAST   = CW_V'(V_TOTAL - 1);
  localparam logic [CW_V-1:0] V_ACT    = CW_V'(V_ACTIVE);
  localparam logic [CW_V-1:0] VS_FIRST = CW_V'(V_ACTIVE + V_FRONT);
  localparam logic [CW_V-1:0] VS_LAST  = CW_V'(V_ACTIVE + V_FRONT + V_SYNC - 1);

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = SYNC_DLY;
`else
  // SYNC_DLY has no effect unless the delay option is built in.
  localparam int DLY = 0 * SYNC_DLY;
`endif

  // Group order: {h_sync, v_sync, blank_n, line_start, frame_start}
  localparam logic [4:0] SYNC_IDLE = {~H_POL, ~V_POL, 3'b000};

  logic [DW-1:0]   r_div;
  logic            r_pix_en;
  logic [CW_H-1:0] r_h_cnt;
  logic [CW_V-1:0] r_v_cnt;
  logic [CW_H-1:0] r_pos_x;
  logic [CW_V-1:0] r_pos_y;
  logic [4:0]      r_sync_grp;

  logic            w_div_wrap;
  logic            w_h_last;
  logic            w_v_last;
  logic [CW_H-1:0] w_h_next;
  logic [CW_V-1:0] w_v_next;
  logic            w_blank_n;
  logic            w_line_start;
  logic            w_h_sync;
  logic            w_v_sync;
  logic [4:0]      w_sync_grp;
  logic [4:0]      w_sync_out;

  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_h_last   = (r_h_cnt == H_LAST);
  assign w_v_last   = (r_v_cnt == V_LAST);

  // Divider free-runs; pix_en is registered so it is high the clk after the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= w_div_wrap ? '0 : r_div + DW'(1);
      r_pix_en <= w_div_wrap;
    end
  end

  // The position shown during a strobe is consumed at that strobe's closing edge,
  // so the first strobe after reset presents 0,0.
  always_comb begin
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (r_pix_en) begin
      w_h_next = w_h_last ? '0 : r_h_cnt + CW_H'(1);
      if (w_h_last) begin
        w_v_next = w_v_last ? '0 : r_v_cnt + CW_V'(1);
      end
    end
  end

  // Decode from the next counter values so registered outputs match the counters.
  assign w_blank_n    = (w_h_next < H_ACT) && (w_v_next < V_ACT);
  assign w_line_start = w_div_wrap && (w_h_next == '0);
  assign w_h_sync     = ((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST)) ? H_POL : ~H_POL;
  assign w_v_sync     = ((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST)) ? V_POL : ~V_POL;
  assign w_sync_grp   = {w_h_sync, w_v_sync, w_blank_n, w_line_start,
                         w_line_start && (w_v_next == '0)};

  // Counters and all outputs load together; reset aborts any line in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_sync_grp <= SYNC_IDLE;
    end else begin
      r_h_cnt    <= w_h_next;
      r_v_cnt    <= w_v_next;
      r_pos_x    <= w_blank_n ? w_h_next : '0;
      r_pos_y    <= w_blank_n ? w_v_next : '0;
      r_sync_grp <= w_sync_grp;
    end
  end

  vga_sync_delay #(
    .WIDTH   (5),
    .DEPTH   (DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .i_d (r_sync_grp),
    .o_q (w_sync_out)
  );

  assign vga.pix_en      = r_pix_en;
  assign vga.pos_x       = r_pos_x;
  assign vga.pos_y       = r_pos_y;
  assign vga.h_sync      = w_sync_out[4];
  assign vga.v_sync      = w_sync_out[3];
  assign vga.blank_n     = w_sync_out[2];
  assign vga.line_start  = w_sync_out[1];
  assign vga.frame_start = w_sync_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of four generator instances:
//   u0 default 640x480, CLK_DIV=1   u1 default, CLK_DIV=4
//   u2 16x10 small frame, positive syncs   u3 16x10 small frame, own reset
// Small frame: H 8/2/3/3 (sync h=10..12), V 6/1/2/1 (sync lines 7..8).
// With CLK_DIV=1, after the k-th clk out of reset the outputs show h=(k-1)%H_TOTAL.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   k = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if #(.CW_H(4), .CW_V(4)) if2 ();
  vga_timing_gen_if #(.CW_H(4), .CW_V(4)) if3 ();

  vga_timing_gen u0 (.clk(clk), .rst(rst_a), .vga(if0));

  vga_timing_gen #(.CLK_DIV(4)) u1 (.clk(clk), .rst(rst_a), .vga(if1));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u2 (.clk(clk), .rst(rst_a), .vga(if2));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u3 (.clk(clk), .rst(rst_b), .vga(if3));

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL k=%0d %s: observed=%b expected=%b", k, tag, obs, exp_v);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL k=%0d %s: observed=%0d expected=%0d", k, tag, obs, exp_v);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL k=%0d %s: observed=%0d expected=%0d", k, tag, obs, exp_v);
    end
  endtask

  // Advance to the negedge following clk edge number 'target'.
  task automatic goto(input int target);
    while (k < target) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    $display("step k=%0d", k);
  endtask

  task automatic chk_u3_reset(input string tag);
    chk1({tag, " u3 pix_en"},      if3.pix_en,      1'b0);
    chk1({tag, " u3 h_sync"},      if3.h_sync,      1'b1);
    chk1({tag, " u3 v_sync"},      if3.v_sync,      1'b1);
    chk1({tag, " u3 blank_n"},     if3.blank_n,     1'b0);
    chk4({tag, " u3 pos_x"},       if3.pos_x,       4'd0);
    chk4({tag, " u3 pos_y"},       if3.pos_y,       4'd0);
    chk1({tag, " u3 line_start"},  if3.line_start,  1'b0);
    chk1({tag, " u3 frame_start"}, if3.frame_start, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk1("rst u0 pix_en", if0.pix_en, 1'b0);
    chk1("rst u0 h_sync", if0.h_sync, 1'b1);
    chk1("rst u0 v_sync", if0.v_sync, 1'b1);
    chk1("rst u0 blank_n", if0.blank_n, 1'b0);
    chk10("rst u0 pos_x", if0.pos_x, 10'd0);
    chk10("rst u0 pos_y", if0.pos_y, 10'd0);
    chk1("rst u0 line_start", if0.line_start, 1'b0);
    chk1("rst u0 frame_start", if0.frame_start, 1'b0);
    chk1("rst u1 pix_en", if1.pix_en, 1'b0);
    chk1("rst u2 h_sync", if2.h_sync, 1'b0);
    chk1("rst u2 v_sync", if2.v_sync, 1'b0);
    chk_u3_reset("rst");
    rst_a = 1'b0;
    rst_b = 1'b0;

    // First strobe out of reset
    goto(1);
    chk1("k1 u0 pix_en", if0.pix_en, 1'b1);
    chk1("k1 u0 frame_start", if0.frame_start, 1'b1);
    chk1("k1 u0 line_start", if0.line_start, 1'b1);
    chk1("k1 u0 blank_n", if0.blank_n, 1'b1);
    chk10("k1 u0 pos_x", if0.pos_x, 10'd0);
    chk10("k1 u0 pos_y", if0.pos_y, 10'd0);
    chk1("k1 u0 h_sync", if0.h_sync, 1'b1);
    chk1("k1 u1 pix_en", if1.pix_en, 1'b0);
    chk1("k1 u1 frame_start", if1.frame_start, 1'b0);
    chk1("k1 u2 h_sync idle", if2.h_sync, 1'b0);
    chk1("k1 u3 frame_start", if3.frame_start, 1'b1);
    goto(2);
    chk10("k2 u0 pos_x", if0.pos_x, 10'd1);
    chk1("k2 u0 frame_start", if0.frame_start, 1'b0);

    // CLK_DIV=4: strobe on the 4th clk, counters frozen between strobes
    goto(3);
    chk1("k3 u1 pix_en", if1.pix_en, 1'b0);
    goto(4);
    chk1("k4 u1 pix_en", if1.pix_en, 1'b1);
    chk1("k4 u1 frame_start", if1.frame_start, 1'b1);
    chk10("k4 u1 pos_x", if1.pos_x, 10'd0);
    goto(5);
    chk1("k5 u1 pix_en", if1.pix_en, 1'b0);
    chk10("k5 u1 pos_x", if1.pos_x, 10'd1);
    chk1("k5 u1 frame_start", if1.frame_start, 1'b0);
    goto(7);
    chk10("k7 u1 pos_x frozen", if1.pos_x, 10'd1);
    goto(8);
    chk1("k8 u1 pix_en", if1.pix_en, 1'b1);
    chk10("k8 u1 pos_x", if1.pos_x, 10'd1);
    chk1("k8 u1 line_start", if1.line_start, 1'b0);

    // Small frame horizontal sync edges (h=10..12)
    goto(10);
    chk1("k10 u3 h_sync", if3.h_sync, 1'b1);
    chk1("k10 u2 h_sync", if2.h_sync, 1'b0);
    goto(11);
    chk1("k11 u3 h_sync", if3.h_sync, 1'b0);
    chk1("k11 u2 h_sync", if2.h_sync, 1'b1);
    goto(13);
    chk1("k13 u3 h_sync", if3.h_sync, 1'b0);
    goto(14);
    chk1("k14 u3 h_sync", if3.h_sync, 1'b1);

    // Small frame active region edges
    goto(88);
    chk1("k88 u3 blank_n", if3.blank_n, 1'b1);
    chk4("k88 u3 pos_x", if3.pos_x, 4'd7);
    chk4("k88 u3 pos_y", if3.pos_y, 4'd5);
    goto(96);
    chk1("k96 u3 blank_n", if3.blank_n, 1'b0);
    chk4("k96 u3 pos_x", if3.pos_x, 4'd0);
    chk4("k96 u3 pos_y", if3.pos_y, 4'd0);
    goto(97);
    chk1("k97 u3 blank_n", if3.blank_n, 1'b0);
    chk1("k97 u3 line_start", if3.line_start, 1'b1);

    // Small frame vertical sync edges (lines 7..8)
    goto(112);
    chk1("k112 u3 v_sync", if3.v_sync, 1'b1);
    chk1("k112 u2 v_sync", if2.v_sync, 1'b0);
    goto(113);
    chk1("k113 u3 v_sync", if3.v_sync, 1'b0);
    chk1("k113 u2 v_sync", if2.v_sync, 1'b1);
    goto(144);
    chk1("k144 u3 v_sync", if3.v_sync, 1'b0);
    goto(145);
    chk1("k145 u3 v_sync", if3.v_sync, 1'b1);

    // Frame wrap: h and v wrap on the same clk
    goto(160);
    chk1("k160 u3 blank_n", if3.blank_n, 1'b0);
    chk1("k160 u3 frame_start", if3.frame_start, 1'b0);
    goto(161);
    chk1("k161 u3 pix_en", if3.pix_en, 1'b1);
    chk1("k161 u3 frame_start", if3.frame_start, 1'b1);
    chk1("k161 u3 line_start", if3.line_start, 1'b1);
    chk1("k161 u3 blank_n", if3.blank_n, 1'b1);
    chk4("k161 u3 pos_x", if3.pos_x, 4'd0);
    chk4("k161 u3 pos_y", if3.pos_y, 4'd0);

    // Vertical period 160 clks
    goto(272);
    chk1("k272 u3 v_sync", if3.v_sync, 1'b1);
    goto(273);
    chk1("k273 u3 v_sync", if3.v_sync, 1'b0);

    // Mid-frame reset of u3 at line 3, h 4
    goto(373);
    chk1("k373 u3 blank_n", if3.blank_n, 1'b1);
    chk4("k373 u3 pos_x", if3.pos_x, 4'd4);
    chk4("k373 u3 pos_y", if3.pos_y, 4'd3);
    rst_b = 1'b1;
    goto(374);
    chk_u3_reset("k374");
    goto(376);
    chk_u3_reset("k376");
    rst_b = 1'b0;
    goto(377);
    chk1("k377 u3 pix_en", if3.pix_en, 1'b1);
    chk1("k377 u3 frame_start", if3.frame_start, 1'b1);
    chk1("k377 u3 blank_n", if3.blank_n, 1'b1);
    chk4("k377 u3 pos_x", if3.pos_x, 4'd0);
    chk4("k377 u3 pos_y", if3.pos_y, 4'd0);
    goto(378);
    chk4("k378 u3 pos_x", if3.pos_x, 4'd1);
    chk1("k378 u3 line_start", if3.line_start, 1'b0);

    // Default line: active edge and sync 656..751
    goto(640);
    chk1("k640 u0 blank_n", if0.blank_n, 1'b1);
    chk10("k640 u0 pos_x", if0.pos_x, 10'd639);
    goto(641);
    chk1("k641 u0 blank_n", if0.blank_n, 1'b0);
    chk10("k641 u0 pos_x", if0.pos_x, 10'd0);
    goto(656);
    chk1("k656 u0 h_sync", if0.h_sync, 1'b1);
    goto(657);
    chk1("k657 u0 h_sync", if0.h_sync, 1'b0);
    goto(752);
    chk1("k752 u0 h_sync", if0.h_sync, 1'b0);
    goto(753);
    chk1("k753 u0 h_sync", if0.h_sync, 1'b1);
    goto(801);
    chk1("k801 u0 line_start", if0.line_start, 1'b1);
    chk1("k801 u0 frame_start", if0.frame_start, 1'b0);
    chk1("k801 u0 blank_n", if0.blank_n, 1'b1);
    chk10("k801 u0 pos_x", if0.pos_x, 10'd0);
    chk10("k801 u0 pos_y", if0.pos_y, 10'd1);
    chk1("k801 u0 v_sync", if0.v_sync, 1'b1);
    goto(1456);
    chk1("k1456 u0 h_sync", if0.h_sync, 1'b1);
    goto(1457);
    chk1("k1457 u0 h_sync", if0.h_sync, 1'b0);

    // CLK_DIV=4 line: sync follows the frozen counter, line period 3200
    goto(2624);
    chk1("k2624 u1 h_sync", if1.h_sync, 1'b1);
    goto(2625);
    chk1("k2625 u1 h_sync", if1.h_sync, 1'b0);
    chk1("k2625 u1 pix_en", if1.pix_en, 1'b0);
    goto(2628);
    chk1("k2628 u1 pix_en", if1.pix_en, 1'b1);
    chk1("k2628 u1 h_sync", if1.h_sync, 1'b0);
    chk10("k2628 u1 pos_x", if1.pos_x, 10'd0);
    goto(3200);
    chk1("k3200 u1 pix_en", if1.pix_en, 1'b1);
    goto(3201);
    chk1("k3201 u1 pix_en", if1.pix_en, 1'b0);
    chk1("k3201 u1 line_start", if1.line_start, 1'b0);
    chk10("k3201 u1 pos_y", if1.pos_y, 10'd1);
    goto(3204);
    chk1("k3204 u1 pix_en", if1.pix_en, 1'b1);
    chk1("k3204 u1 line_start", if1.line_start, 1'b1);
    chk1("k3204 u1 frame_start", if1.frame_start, 1'b0);
    chk10("k3204 u1 pos_x", if1.pos_x, 10'd0);
    chk10("k3204 u1 pos_y", if1.pos_y, 10'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
